// File: rtl/mandelbrot_iter_engine.sv
// Self-iterating Mandelbrot escape-time engine: z <= z^2 + c from z = 0 until escape or the iteration limit.
// One full z update per cycle; done pulses in cycle t+k+2 for a start sampled at edge t; enable low freezes everything.
module mandelbrot_iter_engine #(
    parameter int WIDTH  = 10,
    parameter int FRAC   = 7,
    parameter int ITER_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     start,
    input  logic signed [WIDTH-1:0]  cr,
    input  logic signed [WIDTH-1:0]  ci,
    input  logic [ITER_W-1:0]        max_iter,
    output logic                     busy,
    output logic                     done,
    output logic                     escaped,
    output logic [ITER_W-1:0]        iter_count,
    output logic signed [WIDTH-1:0]  out_zr,
    output logic signed [WIDTH-1:0]  out_zi
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = 2 * WIDTH + 3;
    localparam logic [PW:0] ONE_SQ = 1;
    localparam logic [PW:0] THRESH = ONE_SQ << (2 * FRAC + 2);

    typedef enum logic [1:0] {IDLE, ITERATE, DONE} state_t;

    state_t                     state_q, state_d;
    logic signed [WIDTH-1:0]    cr_q, cr_d, ci_q, ci_d;
    logic signed [WIDTH-1:0]    zr_q, zr_d, zi_q, zi_d;
    logic [ITER_W-1:0]          max_q, max_d, cnt_q, cnt_d;
    logic                       esc_q, esc_d, done_q, done_d;

    logic signed [PW-1:0]       rr, ii, ri;
    logic [PW:0]                sq_sum;
    logic                       esc_now, at_limit;
    logic signed [SW-1:0]       re_wide, im_wide, re_sum, im_sum;

    // Clamp a wide signed value into the WIDTH-bit two's complement range.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] s);
        if (s[SW-1] && !(&s[SW-1:WIDTH-1]))
            return {1'b1, {(WIDTH-1){1'b0}}};
        else if (!s[SW-1] && (|s[SW-1:WIDTH-1]))
            return {1'b0, {(WIDTH-1){1'b1}}};
        else
            return s[WIDTH-1:0];
    endfunction

    always_comb begin
        rr       = zr_q * zr_q;
        ii       = zi_q * zi_q;
        ri       = zr_q * zi_q;
        sq_sum   = {1'b0, rr} + {1'b0, ii};
        esc_now  = sq_sum > THRESH;
        at_limit = cnt_q == max_q;
        re_wide  = ($signed({{3{rr[PW-1]}}, rr}) - $signed({{3{ii[PW-1]}}, ii})) >>> FRAC;
        im_wide  = $signed({{2{ri[PW-1]}}, ri, 1'b0}) >>> FRAC;
        re_sum   = re_wide + $signed({{(SW-WIDTH){cr_q[WIDTH-1]}}, cr_q});
        im_sum   = im_wide + $signed({{(SW-WIDTH){ci_q[WIDTH-1]}}, ci_q});
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else if (enable)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = ITERATE;
            ITERATE:    if (esc_now || at_limit) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = state_q == ITERATE;
        done       = done_q;
        escaped    = esc_q;
        iter_count = cnt_q;
        out_zr     = zr_q;
        out_zi     = zi_q;
    end

    always_comb begin
        cr_d   = cr_q;
        ci_d   = ci_q;
        max_d  = max_q;
        zr_d   = zr_q;
        zi_d   = zi_q;
        cnt_d  = cnt_q;
        esc_d  = esc_q;
        done_d = (state_q == ITERATE) && (state_d == DONE);
        if (state_q != ITERATE) begin
            if (start) begin
                cr_d  = cr;
                ci_d  = ci;
                max_d = max_iter;
                zr_d  = '0;
                zi_d  = '0;
                cnt_d = '0;
                esc_d = 1'b0;
            end
        end else if (esc_now) begin
            esc_d = 1'b1;
        end else if (!at_limit) begin
            zr_d  = sat(re_sum);
            zi_d  = sat(im_sum);
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cr_q   <= '0;
            ci_q   <= '0;
            max_q  <= '0;
            zr_q   <= '0;
            zi_q   <= '0;
            cnt_q  <= '0;
            esc_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (enable) begin
            cr_q   <= cr_d;
            ci_q   <= ci_d;
            max_q  <= max_d;
            zr_q   <= zr_d;
            zi_q   <= zi_d;
            cnt_q  <= cnt_d;
            esc_q  <= esc_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Directed bench for mandelbrot_iter_engine with a per-run trajectory model and per-cycle output compare.
module tb_mandelbrot_iter_engine;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic              start = 1'b0;
    logic signed [9:0] cr = '0;
    logic signed [9:0] ci = '0;
    logic [7:0]        max_iter = '0;
    logic              busy, done, escaped;
    logic [7:0]        iter_count;
    logic signed [9:0] out_zr, out_zi;

    mandelbrot_iter_engine #(.WIDTH(10), .FRAC(7), .ITER_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .cr(cr), .ci(ci), .max_iter(max_iter),
        .busy(busy), .done(done), .escaped(escaped), .iter_count(iter_count),
        .out_zr(out_zr), .out_zi(out_zi)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;
    int t_start = 0;
    bit cmp_on = 0;

    // Model: mode 0 = idle; mode 1 = a run whose whole trajectory is known.
    // n counts enabled edges since (and including) the accepted start edge.
    int m_mode = 0;
    int m_n = 0;
    int m_k = 0;
    int m_esc = 0;
    int hzr [0:256];
    int hzi [0:256];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic int satv(input int v);
        if (v > 511) return 511;
        if (v < -512) return -512;
        return v;
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        int zr, zi, nr, ni;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_mode = 0;
                m_n = 0;
            end else if (enable) begin
                if (start && (m_mode == 0 || m_n >= m_k + 2)) begin
                    zr = 0;
                    zi = 0;
                    m_esc = 0;
                    m_k = 0;
                    for (int k = 0; k <= 256; k++) begin
                        hzr[k] = zr;
                        hzi[k] = zi;
                        m_k = k;
                        if (zr * zr + zi * zi > 4 * 16384) begin
                            m_esc = 1;
                            break;
                        end
                        if (k == int'(max_iter)) break;
                        nr = satv(((zr * zr - zi * zi) >>> 7) + int'(cr));
                        ni = satv(((2 * zr * zi) >>> 7) + int'(ci));
                        zr = nr;
                        zi = ni;
                    end
                    m_mode = 1;
                    m_n = 1;
                end else if (m_mode == 1) begin
                    m_n++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                if (m_mode == 0) begin
                    chk("busy", int'(busy), 0);
                    chk("done", int'(done), 0);
                    chk("escaped", int'(escaped), 0);
                    chk("iter_count", int'(iter_count), 0);
                    chk("out_zr", int'(out_zr), 0);
                    chk("out_zi", int'(out_zi), 0);
                end else if (m_n <= m_k + 1) begin
                    chk("busy", int'(busy), 1);
                    chk("done", int'(done), 0);
                    chk("escaped", int'(escaped), 0);
                    chk("iter_count", int'(iter_count), m_n - 1);
                    chk("out_zr", int'(out_zr), hzr[m_n - 1]);
                    chk("out_zi", int'(out_zi), hzi[m_n - 1]);
                end else begin
                    chk("busy", int'(busy), 0);
                    chk("done", int'(done), int'(m_n == m_k + 2));
                    chk("escaped", int'(escaped), m_esc);
                    chk("iter_count", int'(iter_count), m_k);
                    chk("out_zr", int'(out_zr), hzr[m_k]);
                    chk("out_zi", int'(out_zi), hzi[m_k]);
                end
            end
        end
    end

    // Assumes the caller is away from a clock edge; start is seen on the next edge.
    task automatic launch(input int c_r, input int c_i, input int mi);
        cr = 10'(c_r);
        ci = 10'(c_i);
        max_iter = 8'(mi);
        start = 1'b1;
        @(posedge clk);
        #1;
        t_start = edge_cnt;
        start = 1'b0;
    endtask

    // Returns done's cycle offset from the start (cycle t+1 follows edge t), or -1 on timeout.
    task automatic wait_done(output int off);
        off = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                off = edge_cnt - t_start + 1;
                return;
            end
        end
    endtask

    initial begin
        int off;
        int seen;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cmp_on = 1'b1;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_count", int'(iter_count), 0);

        launch(0, 0, 20);
        wait_done(off);
        chk("t1_done_cycle", off, 22);
        chk("t1_escaped", int'(escaped), 0);
        chk("t1_count", int'(iter_count), 20);
        chk("t1_zr", int'(out_zr), 0);

        launch(384, 0, 20);
        wait_done(off);
        chk("t2_done_cycle", off, 3);
        chk("t2_escaped", int'(escaped), 1);
        chk("t2_count", int'(iter_count), 1);
        chk("t2_zr", int'(out_zr), 384);

        launch(256, 0, 20);
        wait_done(off);
        chk("t3_done_cycle", off, 4);
        chk("t3_escaped", int'(escaped), 1);
        chk("t3_count", int'(iter_count), 2);
        chk("t3_zr", int'(out_zr), 511);
        chk("t3_zi", int'(out_zi), 0);

        launch(-128, 0, 10);
        wait_done(off);
        chk("t4_done_cycle", off, 12);
        chk("t4_escaped", int'(escaped), 0);
        chk("t4_count", int'(iter_count), 10);
        chk("t4_zr", int'(out_zr), 0);

        launch(-128, 0, 0);
        wait_done(off);
        chk("t5_done_cycle", off, 2);
        chk("t5_count", int'(iter_count), 0);
        chk("t5_escaped", int'(escaped), 0);

        // Start pulse mid-run with a different c must not disturb the run.
        launch(0, 0, 20);
        repeat (5) @(negedge clk);
        cr = 10'sd384;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(off);
        chk("t6_done_cycle", off, 22);
        chk("t6_escaped", int'(escaped), 0);
        chk("t6_count", int'(iter_count), 20);

        // Three disabled cycles mid-run delay done by exactly three cycles.
        launch(0, 0, 20);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
        wait_done(off);
        chk("t7_done_cycle", off, 25);
        chk("t7_count", int'(iter_count), 20);

        // Disabled in the done cycle: the pulse stays up until the next enabled edge.
        launch(384, 0, 20);
        wait_done(off);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t8_done_held", int'(done), 1);
        enable = 1'b1;
        @(negedge clk);
        chk("t8_done_cleared", int'(done), 0);

        // Start issued in the done cycle launches the next run on that edge.
        launch(0, 0, 3);
        wait_done(off);
        chk("t9a_done_cycle", off, 5);
        launch(384, 0, 20);
        chk("t9_busy_now", int'(busy), 1);
        wait_done(off);
        chk("t9b_done_cycle", off, 3);
        chk("t9b_count", int'(iter_count), 1);

        // Reset mid-run aborts cleanly and no done pulse follows.
        launch(0, 0, 20);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t10_busy", int'(busy), 0);
        chk("t10_count", int'(iter_count), 0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("t10_no_done", seen, 0);
        launch(256, 0, 20);
        wait_done(off);
        chk("t10_rerun_cycle", off, 4);
        chk("t10_rerun_zr", int'(out_zr), 511);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mandelbrot_iter_engine.md
# mandelbrot_iter_engine

Parametrised, self-iterating Mandelbrot escape-time engine: a successor to the single-step combinational Mandelbrot datapath used in size-exploration builds. Given a point c, it runs z ← z² + c from z = 0 until it detects escape or reaches a run-time iteration limit. It then reports the iteration count, the escape flag and the final z. It sits behind the serial input loader of the size-exploration top, which drives `cr`, `ci`, `max_iter` and `start`, and muxes the results onto the output pins.

## Interface
- `WIDTH`, 10: signed fixed-point width of `cr`, `ci`, `zr`, `zi` (two's complement)
- `FRAC`, 7: fractional bits; 1.0 = 2^FRAC. Constraint: WIDTH-FRAC ≥ 3
- `ITER_W`, 8: width of `max_iter` and `iter_count`

- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `enable` in 1: clock enable; low freezes all state
- `start` in 1: begin a run; sampled on the rising edge
- `cr`, `ci` in WIDTH each: c real/imag, latched on the accepted `start`
- `max_iter` in ITER_W: iteration limit, latched on the accepted `start`
- `busy` out 1: high in ITERATE
- `done` out 1: one-cycle pulse when a run completes
- `escaped` out 1: 1 = run ended by escape, 0 = run ended by limit
- `iter_count` out ITER_W: number of z updates performed
- `out_zr`, `out_zi` out WIDTH each: current/final z

## Operation
- States: IDLE, ITERATE, DONE. Reset → IDLE; `busy`, `done`, `escaped`, `iter_count`, `out_zr`, `out_zi` all 0.
- IDLE/DONE + `start` (with `enable` high):
  - latch c and `max_iter`
  - z := 0, count := 0, `escaped` := 0
  - → ITERATE
- `start` during ITERATE is ignored.
- Each ITERATE cycle performs, in order:
  - **Escape check on the current z:** exact unsigned sum zr²+zi² (2·WIDTH+1 bits, no truncation). Escaped iff the sum is strictly greater than 4·2^(2·FRAC). If escaped: `escaped` := 1, → DONE, z and count unchanged.
  - **Limit check:** if count == max_iter → DONE with `escaped` = 0, z unchanged.
  - **Update otherwise:**
    - zr' = sat((zr²−zi²) >>> FRAC + cr)
    - zi' = sat((2·zr·zi) >>> FRAC + ci)
    - count += 1
    - Products are full 2·WIDTH signed. `>>>` is an arithmetic shift (floor). Sums are formed one bit wider than needed. sat() clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- DONE:
  - `done` = 1 in the first DONE cycle only.
  - Results are held until the next accepted `start` or `reset`.
  - Remains in DONE until `start`; `start` from DONE restarts immediately, with no return to IDLE.
- `out_zr`, `out_zi`, `iter_count` track the live registers during ITERATE.
- `enable` low: state, z, count and `done` are frozen; `start` is ignored. A pending `done` pulse stays high until the first enabled cycle.
- `reset` mid-run: the run is aborted and all outputs return to reset values on the next edge.

## Timing
- `start` sampled at edge t → ITERATE from cycle t+1, `busy` = 1.
- A run performing k updates ends by escape with `done` in cycle t+k+2, or by limit (k = max_iter) with `done` in cycle t+max_iter+2. This assumes `enable` stays high.
- `busy` falls in the same cycle `done` rises.
- Each cycle with `enable` low adds one cycle of latency.
- Full z update in one cycle: single-cycle multiply path, with no pipelining in this generation.

## Test plan
Values use WIDTH=10, FRAC=7 (1.0 = 128).
- **Non-escaping point:** cr=0, ci=0, max_iter=20, start at t → `done` at t+22, escaped=0, iter_count=20, zr=zi=0; `busy` high for cycles t+1..t+21.
- **Immediate escape:** cr=384 (3.0), ci=0, max_iter=20 → after 1 update zr=384, sum 147456 > 65536 → escaped=1, iter_count=1, out_zr=384, `done` at t+3.
- **Escape threshold and saturation:** cr=256 (2.0), ci=0, max_iter=20.
  - Update 1 gives zr=256; sum 65536 equals the threshold, so no escape.
  - Update 2: 512+256 saturates to zr=511.
  - Result: escaped=1, iter_count=2, out_zr=511, out_zi=0.
- **Periodic orbit and zero limit:**
  - cr=−128, ci=0, max_iter=10 → escaped=0, iter_count=10, zr=0, zi=0.
  - Rerun with max_iter=0 → `done` at t+2, iter_count=0, escaped=0.
- **Handshake and control:**
  - `start` pulsed mid-run is ignored; the result is unchanged.
  - `enable` held low for 3 cycles mid-run delays `done` by exactly 3 cycles; the result is identical.
  - `start` in the DONE cycle launches a new run at once.
- **Reset mid-run:** `reset` asserted during ITERATE → next cycle state IDLE, all outputs 0, no `done` pulse; a following `start` runs normally.
